// File: rtl/cnn_ctrl_pkg.sv
// Shared control definitions for the CNN layer sequencers: sequencer states,
// default layer geometry and helpers deriving per-layer output counts.
package cnn_ctrl_pkg;

    localparam int NUM_COLS      = 12;
    localparam int KERNEL_SIZE   = 3;
    localparam int WARMUP_CYCLES = 4;

    typedef enum logic [2:0] {
        ST_WARMUP = 3'd0,
        ST_IDLE   = 3'd1,
        ST_FETCH  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } seq_state_e;

    // Columns produced by a valid (unpadded) convolution across the image width.
    function automatic int conv_out_cols(input int num_cols, input int kernel_size);
        return num_cols - kernel_size + 1;
    endfunction

    // Pair-wise pooling halves the conv output, dropping an odd trailing column.
    function automatic int pool_out_cols(input int num_cols, input int kernel_size);
        return (num_cols - kernel_size + 1) / 2;
    endfunction

endpackage

// File: rtl/conv_layer_sequencer.sv
// Walks one image column by column from the column buffer into the first conv
// layer, then waits for the conv and pooled outputs to drain before completing.
module conv_layer_sequencer #(
    parameter int NUM_COLS      = cnn_ctrl_pkg::NUM_COLS,
    parameter int KERNEL_SIZE   = cnn_ctrl_pkg::KERNEL_SIZE,
    parameter int WARMUP_CYCLES = cnn_ctrl_pkg::WARMUP_CYCLES,
    parameter int ADDR_WIDTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  out_ready,
    output logic                  col_rd_en,
    output logic [ADDR_WIDTH-1:0] col_rd_addr,
    input  logic                  col_rd_valid,
    output logic                  conv_valid_in,
    input  logic                  conv_column_valid,
    input  logic                  conv_pool_valid,
    output logic                  busy,
    output logic                  done
);
    import cnn_ctrl_pkg::*;

    localparam int CNT_W  = $clog2(NUM_COLS + 1);
    localparam int WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  LAST_COL     = CNT_W'(NUM_COLS - 1);
    localparam logic [CNT_W-1:0]  FETCH_TARGET = CNT_W'(NUM_COLS);
    localparam logic [CNT_W-1:0]  COL_TARGET   = CNT_W'(conv_out_cols(NUM_COLS, KERNEL_SIZE));
    localparam logic [CNT_W-1:0]  POOL_TARGET  = CNT_W'(pool_out_cols(NUM_COLS, KERNEL_SIZE));
    localparam logic [WARM_W-1:0] WARM_LAST    = WARM_W'(WARMUP_CYCLES - 1);

    seq_state_e        state_q, state_d;
    logic [WARM_W-1:0] warm_cnt_q, warm_cnt_d;
    logic [CNT_W-1:0]  fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0]  col_cnt_q, col_cnt_d;
    logic [CNT_W-1:0]  pool_cnt_q, pool_cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_en_s;
    logic              conv_valid_s;
    logic              counting_s;

    // Next-state, counter and strobe logic for the image walk.
    always_comb begin
        state_d      = state_q;
        warm_cnt_d   = warm_cnt_q;
        fetch_cnt_d  = fetch_cnt_q;
        col_cnt_d    = col_cnt_q;
        pool_cnt_d   = pool_cnt_q;
        rd_en_s      = 1'b0;
        conv_valid_s = 1'b0;

        case (state_q)
            ST_WARMUP: begin
                if (warm_cnt_q == WARM_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    warm_cnt_d = warm_cnt_q + WARM_W'(1);
                end
            end
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_FETCH;
                    fetch_cnt_d = '0;
                    col_cnt_d   = '0;
                    pool_cnt_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (out_ready) begin
                    rd_en_s = 1'b1;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_WAIT: begin
                // Data is forwarded in the cycle it returns so a 1-cycle buffer sustains a column every 2 cycles.
                if (col_rd_valid) begin
                    conv_valid_s = 1'b1;
                    state_d      = (fetch_cnt_q < LAST_COL) ? ST_FETCH : ST_DRAIN;
                    if (fetch_cnt_q != FETCH_TARGET) begin
                        fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
                    end else begin
                        fetch_cnt_d = fetch_cnt_q;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if ((pool_cnt_q == POOL_TARGET) && (col_cnt_q == COL_TARGET)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_WARMUP;
            end
        endcase

        // Layer output pulses are tallied while an image is in flight and clamp at their targets.
        if (counting_s && conv_column_valid && (col_cnt_q != COL_TARGET)) begin
            col_cnt_d = col_cnt_q + CNT_W'(1);
        end else begin
            col_cnt_d = col_cnt_d;
        end
        if (counting_s && conv_pool_valid && (pool_cnt_q != POOL_TARGET)) begin
            pool_cnt_d = pool_cnt_q + CNT_W'(1);
        end else begin
            pool_cnt_d = pool_cnt_d;
        end

        busy_d = (state_d != ST_WARMUP) && (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    assign counting_s = (state_q == ST_FETCH) || (state_q == ST_WAIT) || (state_q == ST_DRAIN);

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_WARMUP;
            warm_cnt_q  <= '0;
            fetch_cnt_q <= '0;
            col_cnt_q   <= '0;
            pool_cnt_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            warm_cnt_q  <= warm_cnt_d;
            fetch_cnt_q <= fetch_cnt_d;
            col_cnt_q   <= col_cnt_d;
            pool_cnt_q  <= pool_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign col_rd_en     = rd_en_s;
    assign col_rd_addr   = ADDR_WIDTH'(fetch_cnt_q);
    assign conv_valid_in = conv_valid_s;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Bench for conv_layer_sequencer: a column buffer and conv/pool layer model
// respond to the sequencer while address order and pulse counts are checked.
module tb_conv_layer_sequencer;

    localparam int NUM_COLS      = 12;
    localparam int KERNEL_SIZE   = 3;
    localparam int WARMUP_CYCLES = 4;
    localparam int ADDR_WIDTH    = 4;
    localparam int COL_EXP       = NUM_COLS - KERNEL_SIZE + 1;
    localparam int POOL_EXP      = COL_EXP / 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic                  out_ready = 1'b1;
    logic                  col_rd_en;
    logic [ADDR_WIDTH-1:0] col_rd_addr;
    logic                  col_rd_valid = 1'b0;
    logic                  conv_valid_in;
    logic                  conv_column_valid = 1'b0;
    logic                  conv_pool_valid = 1'b0;
    logic                  busy;
    logic                  done;

    conv_layer_sequencer #(
        .NUM_COLS      (NUM_COLS),
        .KERNEL_SIZE   (KERNEL_SIZE),
        .WARMUP_CYCLES (WARMUP_CYCLES),
        .ADDR_WIDTH    (ADDR_WIDTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .out_ready         (out_ready),
        .col_rd_en         (col_rd_en),
        .col_rd_addr       (col_rd_addr),
        .col_rd_valid      (col_rd_valid),
        .conv_valid_in     (conv_valid_in),
        .conv_column_valid (conv_column_valid),
        .conv_pool_valid   (conv_pool_valid),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // scenario knobs
    int lat_min, lat_max, extra_cols, stall_col, stall_len, busy_start_at;
    bit rand_ready, spurious_en, start_in_done, chk_tput;

    // reference model state
    int exp_addr, n_conv, n_col_emit, n_pool_emit, n_done;
    int pend_lat, col_pend, pool_pend, stall_left, last_en, cyc_now = 0;
    bit pending, resp_now, stall_done, busy_start_done;

    task automatic configure(input int lmin, input int lmax, input bit rr, input bit sp,
                             input int ex, input int sc, input int sl, input int bs,
                             input bit sid, input bit tp);
        lat_min = lmin; lat_max = lmax; rand_ready = rr; spurious_en = sp;
        extra_cols = ex; stall_col = sc; stall_len = sl; busy_start_at = bs;
        start_in_done = sid; chk_tput = tp;
    endtask

    task automatic clear_model();
        exp_addr = 0; n_conv = 0; n_col_emit = 0; n_pool_emit = 0; n_done = 0;
        pend_lat = 0; col_pend = 0; pool_pend = 0; stall_left = 0; last_en = -1;
        pending = 1'b0; resp_now = 1'b0; stall_done = 1'b0; busy_start_done = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1; start = 1'b0; out_ready = 1'b1; col_rd_valid = 1'b0;
        conv_column_valid = 1'b0; conv_pool_valid = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (WARMUP_CYCLES) @(posedge clk);
        #1;
    endtask

    // One clock of the environment: observe at negedge, then drive the buffer and layer models.
    task automatic run_cycle();
        @(negedge clk);
        cyc_now++;
        vectors++;
        if (conv_valid_in !== (col_rd_valid && resp_now)) begin
            miscompares++;
            $display("FAIL conv_valid_in cyc %0d: got %b expected %b", cyc_now, conv_valid_in, col_rd_valid && resp_now);
        end
        if (conv_valid_in === 1'b1) n_conv++;
        if (conv_valid_in === 1'b1 && resp_now) begin
            if (n_conv >= KERNEL_SIZE) col_pend++;
            if (n_conv == NUM_COLS) col_pend += extra_cols;
        end
        if (col_rd_en === 1'b1) begin
            vectors++;
            if (pending || !out_ready || col_rd_addr !== ADDR_WIDTH'(exp_addr)) begin
                miscompares++;
                $display("FAIL read_req cyc %0d: got addr %0d pending %0b ready %0b, expected addr %0d no pending ready 1",
                         cyc_now, col_rd_addr, pending, out_ready, exp_addr);
            end
            if (chk_tput && last_en >= 0) begin
                vectors++;
                if (cyc_now - last_en != 2) begin
                    miscompares++;
                    $display("FAIL throughput: got gap %0d expected 2", cyc_now - last_en);
                end
            end
            last_en = cyc_now;
            exp_addr++;
            pending = 1'b1;
            pend_lat = $urandom_range(lat_max, lat_min);
        end
        if (done === 1'b1) begin
            n_done++;
            vectors++;
            if (exp_addr != NUM_COLS || n_col_emit < COL_EXP || n_pool_emit < POOL_EXP) begin
                miscompares++;
                $display("FAIL done_cond: got addr %0d cols %0d pools %0d expected %0d %0d %0d",
                         exp_addr, n_col_emit, n_pool_emit, NUM_COLS, COL_EXP, POOL_EXP);
            end
            if (start_in_done) start = 1'b1;
        end

        @(posedge clk);
        #1;
        start = (busy_start_at >= 0 && exp_addr == busy_start_at && !busy_start_done);
        if (start) busy_start_done = 1'b1;

        resp_now = 1'b0;
        col_rd_valid = 1'b0;
        if (pending) begin
            pend_lat--;
            if (pend_lat <= 0) begin
                col_rd_valid = 1'b1; resp_now = 1'b1; pending = 1'b0;
            end
        end else if (spurious_en) begin
            col_rd_valid = ($urandom_range(2, 0) == 0);
        end

        conv_column_valid = 1'b0;
        conv_pool_valid = 1'b0;
        if (pool_pend > 0) begin
            conv_pool_valid = 1'b1; pool_pend--; n_pool_emit++;
        end
        if (col_pend > 0) begin
            conv_column_valid = 1'b1; col_pend--; n_col_emit++;
            if (n_col_emit <= COL_EXP && n_col_emit % 2 == 0) pool_pend++;
        end

        if (stall_left > 0) begin
            out_ready = 1'b0; stall_left--;
        end else if (stall_col >= 0 && exp_addr == stall_col && !stall_done) begin
            stall_done = 1'b1; stall_left = stall_len - 1; out_ready = 1'b0;
        end else begin
            out_ready = rand_ready ? ($urandom_range(3, 0) != 0) : 1'b1;
        end
    endtask

    task automatic run_image(output bit finished);
        int cyc = 0;
        start = 1'b1;
        while (n_done == 0 && cyc < 400) begin
            run_cycle();
            cyc++;
        end
        finished = (n_done > 0);
    endtask

    task automatic check_image(input string tag, input bit finished);
        vectors++;
        if (!finished) begin
            miscompares++;
            $display("FAIL %s timeout: got no done, expected done within 400 cycles", tag);
        end
        repeat (3) run_cycle();
        vectors++;
        if (exp_addr != NUM_COLS) begin
            miscompares++;
            $display("FAIL %s reads: got %0d expected %0d", tag, exp_addr, NUM_COLS);
        end
        vectors++;
        if (n_conv != NUM_COLS) begin
            miscompares++;
            $display("FAIL %s conv_valid_in count: got %0d expected %0d", tag, n_conv, NUM_COLS);
        end
        vectors++;
        if (n_done != 1) begin
            miscompares++;
            $display("FAIL %s done count: got %0d expected 1", tag, n_done);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy after: got %b expected 0", tag, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; out_ready = 1'b1; col_rd_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({col_rd_en, col_rd_addr, conv_valid_in, busy, done} !== '0) begin
            miscompares++;
            $display("FAIL reset outputs: got en %b addr %0d cv %b busy %b done %b expected all 0",
                     col_rd_en, col_rd_addr, conv_valid_in, busy, done);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || col_rd_en !== 1'b0) begin
            miscompares++;
            $display("FAIL warmup start: got busy %b en %b expected 0 0", busy, col_rd_en);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle busy: got %b expected 0", busy);
        end
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || col_rd_en !== 1'b1 || col_rd_addr !== '0) begin
            miscompares++;
            $display("FAIL first fetch: got busy %b en %b addr %0d expected 1 1 0", busy, col_rd_en, col_rd_addr);
        end
    endtask

    task automatic test_basic();
        bit fin;
        configure(1, 1, 1'b0, 1'b0, 0, -1, 0, -1, 1'b0, 1'b1);
        apply_reset();
        run_image(fin);
        check_image("basic", fin);
    endtask

    task automatic test_back_to_back();
        bit fin;
        configure(1, 1, 1'b0, 1'b0, 0, -1, 0, -1, 1'b0, 1'b1);
        apply_reset();
        run_image(fin);
        check_image("b2b_first", fin);
        clear_model();
        run_image(fin);
        check_image("b2b_second", fin);
    endtask

    task automatic test_stall();
        bit fin;
        configure(1, 1, 1'b0, 1'b0, 0, 6, 5, -1, 1'b0, 1'b0);
        apply_reset();
        run_image(fin);
        check_image("stall", fin);
    endtask

    task automatic test_latency_spurious();
        bit fin;
        configure(3, 3, 1'b0, 1'b1, 0, -1, 0, -1, 1'b0, 1'b0);
        apply_reset();
        run_image(fin);
        check_image("lat3_spurious", fin);
    endtask

    task automatic test_busy_start();
        bit fin;
        configure(1, 2, 1'b0, 1'b0, 3, -1, 0, 4, 1'b1, 1'b0);
        apply_reset();
        run_image(fin);
        check_image("busy_start_saturate", fin);
    endtask

    task automatic test_random();
        bit fin;
        for (int i = 0; i < 4; i++) begin
            configure(1, $urandom_range(3, 1), 1'b1, 1'b1, $urandom_range(2, 0), -1, 0,
                      $urandom_range(10, 1), 1'b1, 1'b0);
            apply_reset();
            run_image(fin);
            check_image("random", fin);
        end
    endtask

    task automatic test_reset_mid();
        bit fin;
        int cyc = 0;
        configure(1, 1, 1'b0, 1'b0, 0, -1, 0, -1, 1'b0, 1'b0);
        apply_reset();
        start = 1'b1;
        while (exp_addr < 8 && cyc < 100) begin
            run_cycle();
            cyc++;
        end
        col_rd_valid = 1'b1;
        rst = 1'b1;
        #1;
        vectors++;
        if ({col_rd_en, col_rd_addr, conv_valid_in, busy, done} !== '0) begin
            miscompares++;
            $display("FAIL mid reset outputs: got en %b addr %0d cv %b busy %b done %b expected all 0",
                     col_rd_en, col_rd_addr, conv_valid_in, busy, done);
        end
        @(posedge clk); #1 rst = 1'b0; start = 1'b1;
        @(negedge clk);
        vectors++;
        if (conv_valid_in !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL late valid: got cv %b busy %b expected 0 0", conv_valid_in, busy);
        end
        @(posedge clk); #1 start = 1'b0; col_rd_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL restart warmup: got busy %b expected 0", busy);
        end
        repeat (3) @(posedge clk);
        #1;
        clear_model();
        run_image(fin);
        check_image("after_reset", fin);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_latency_spurious();
        test_busy_start();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of run, expected finish before 500000 time units");
        $fatal(1);
    end

endmodule

// File: doc/conv_layer_sequencer.md
CONV_LAYER_SEQUENCER -- requirements
Module: conv_layer_sequencer

Interface
REQ-001 SHALL have parameter NUM_COLS, default 12: input columns per image (image width).
REQ-002 SHALL have parameter KERNEL_SIZE, default 3: convolution kernel width.
REQ-003 SHALL have parameter WARMUP_CYCLES, default 4: cycles after reset the conv layer spends loading kernels.
REQ-004 SHALL have parameter ADDR_WIDTH, default 4: column buffer address width.
REQ-005 SHALL have port clk, input, 1: clock, rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port start, input, 1: single-cycle request to process one image.
REQ-008 SHALL have port out_ready, input, 1: downstream can accept one further pooled column.
REQ-009 SHALL have port col_rd_en, output, 1: column buffer read request.
REQ-010 SHALL have port col_rd_addr, output, ADDR_WIDTH: column index being read.
REQ-011 SHALL have port col_rd_valid, input, 1: buffer data valid, returned 1..N cycles after col_rd_en.
REQ-012 SHALL have port conv_valid_in, output, 1: drives conv layer valid_in.
REQ-013 SHALL have ports conv_column_valid and conv_pool_valid, input, 1 each: conv layer column_valid_out and valid_out.
REQ-014 SHALL have ports busy and done, output, 1 each: image in progress; one-cycle completion pulse.

Function
REQ-015 SHALL implement states WARMUP, IDLE, FETCH, WAIT, DRAIN, DONE.
REQ-016 WARMUP: count WARMUP_CYCLES cycles from reset release, then -> IDLE; start ignored in WARMUP.
REQ-017 IDLE: start=1 -> FETCH, clear all counters; busy=1 in every state except WARMUP and IDLE.
REQ-018 FETCH: when out_ready=1, assert col_rd_en for exactly one cycle with col_rd_addr = fetch count, -> WAIT; when out_ready=0, stay with col_rd_en=0.
REQ-019 WAIT: conv_valid_in = col_rd_valid (combinational, same cycle); on col_rd_valid increment fetch count; -> FETCH if fetch count < NUM_COLS-1 before increment, else -> DRAIN.
REQ-020 At most one read outstanding; col_rd_valid outside WAIT SHALL be ignored and SHALL NOT assert conv_valid_in.
REQ-021 Count conv_column_valid pulses (expected NUM_COLS-KERNEL_SIZE+1) and conv_pool_valid pulses (expected (NUM_COLS-KERNEL_SIZE+1)/2).
REQ-022 DRAIN: when pooled count reaches expected -> DONE; column count SHALL have reached its expected value by then.
REQ-023 DONE: done=1 for one cycle, -> IDLE; start in DONE ignored.
REQ-024 Counters SHALL saturate at their expected value; extra pulses SHALL NOT wrap.
REQ-025 start while busy SHALL be ignored (no queueing).
REQ-026 Counter widths SHALL be $clog2(NUM_COLS+1) bits.
REQ-027 Throughput: one column per 2 cycles minimum (FETCH+WAIT with 1-cycle read latency).

Reset
REQ-028 On rst: state=WARMUP, counters=0, col_rd_en=0, col_rd_addr=0, conv_valid_in=0, busy=0, done=0.
REQ-029 Reset mid-image SHALL abandon the image; a late col_rd_valid after reset SHALL be ignored.

Structure
REQ-030 State enum and shared layer geometry constants (NUM_COLS, KERNEL_SIZE, WARMUP_CYCLES) SHALL reside in shared package cnn_ctrl_pkg.
REQ-031 Single module, no sub-modules; instantiated beside conv_layer_1 and a column buffer.

Verification
REQ-032 Reset release, start at cycle 2 -> ignored; start after 4 cycles -> busy=1 next cycle, first col_rd_addr=0.
REQ-033 12 columns, 1-cycle read latency, out_ready=1, model emits 10 column / 5 pool pulses -> addresses 0..11 each once, 12 conv_valid_in pulses, done exactly once, then busy=0.
REQ-034 out_ready=0 for 5 cycles at column 6 -> no col_rd_en during stall, resume at addr 6, no skipped or repeated address.
REQ-035 Read latency 3 cycles, spurious col_rd_valid in FETCH -> no conv_valid_in for spurious pulse; total conv_valid_in=12.
REQ-036 start pulsed during busy -> no effect; rst asserted at column 7 -> outputs at reset values, WARMUP restarts, next image starts at addr 0.
